// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer: drives one external 4-bit ripple-carry adder through
// WIDTH/4 nibble steps, LSB nibble first. It holds the inter-nibble carry and
// assembles the WIDTH-bit sum/difference together with the carry-out and the
// signed-overflow flags.
module rca_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [3:0]       rca_a,
  output logic [3:0]       rca_b,
  output logic             rca_cin,
  input  logic [3:0]       rca_s,
  input  logic             rca_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NNIB = WIDTH / 4;
  localparam int unsigned KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       nib_a, nib_b;
  logic             last_step;

  // Next-state logic: accept a request, or take one nibble step of the adder
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    nib_a   = '0;
    nib_b   = '0;

    // Select the operand nibbles for the current step.
    for (int unsigned i = 0; i < NNIB; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end

    last_step = (k_q == KW'(NNIB - 1));

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NNIB; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[4*i +: 4] = rca_s;
          end
        end
        carry_d = rca_cout;
        if (last_step) begin
          cout_d  = rca_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (rca_s[3] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Adder drive is gated to zero outside RUN; status decoded from state
  always_comb begin
    rca_a   = '0;
    rca_b   = '0;
    rca_cin = 1'b0;
    if (state_q == RUN) begin
      rca_a   = nib_a;
      rca_b   = nib_b;
      rca_cin = carry_q;
    end
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Testbench for rca_nibble_sequencer: behavioural integer reference model,
// directed corner cases plus randomized add/sub traffic.
module tb_rca_nibble_sequencer;

  localparam int unsigned W    = 16;
  localparam int unsigned NNIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [3:0]   rca_a, rca_b, rca_s;
  logic         rca_cin, rca_cout;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External 4-bit adder
  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0, rca_cin};

  rca_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin), .rca_s(rca_s),
    .rca_cout(rca_cout), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands
  task automatic model(input logic [W-1:0] ma, mb, input logic mcin, msub,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    longint ua, ub, sa, sb, r;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      r  = ua - ub - longint'(mcin);
      ec = (ua >= ub + longint'(mcin));
      sa = sa - sb - longint'(mcin);
    end else begin
      r  = ua + ub + longint'(mcin);
      ec = (r >= (64'sd1 <<< W));
      sa = sa + sb + longint'(mcin);
    end
    es = r[W-1:0];
    eo = (sa > (64'sd1 <<< (W-1)) - 1) || (sa < -(64'sd1 <<< (W-1)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_rca"}, {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
  endtask

  // One operation from IDLE; optional spurious start pulse during RUN
  task automatic run_op(input logic [W-1:0] ta, tb_, input logic tcin, tsub, input bit glitch);
    logic [W-1:0] es, eb;
    logic ec, eo;
    int cnt;
    model(ta, tb_, tcin, tsub, es, ec, eo);
    eb = tsub ? ~tb_ : tb_;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int s = 0; s < int'(NNIB); s++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("rca_a", 32'(rca_a), 32'(ta[4*s +: 4]));
      chk("rca_b", 32'(rca_b), 32'(eb[4*s +: 4]));
      if (s == 0) chk("rca_cin0", 32'(rca_cin), 32'(tcin ^ tsub));
      if (glitch && s == 1) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      if (s == 2) start = 1'b0;
      @(negedge clk);
    end
    cnt = 0;
    while (!done && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'd0);
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum), 32'(es));
    chk("rca_idle", {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] qa[5], qb[5], es;
    logic qc[5], qs[5], ec, eo;
    int cnt;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    // Directed corner cases
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Back-to-back with start held high
    for (int j = 0; j < 5; j++) begin
      qa[j] = W'($urandom); qb[j] = W'($urandom);
      qc[j] = 1'($urandom); qs[j] = 1'($urandom);
    end
    @(negedge clk);
    a = qa[0]; b = qb[0]; cin = qc[0]; sub = qs[0]; start = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done && cnt < 20);
      model(qa[j], qb[j], qc[j], qs[j], es, ec, eo);
      chk("b2b_period", 32'(cnt), 32'(NNIB + 1));
      chk("b2b_sum", 32'(sum), 32'(es));
      chk("b2b_cout", 32'(cout), 32'(ec));
      chk("b2b_ovf", 32'(ovf), 32'(eo));
      if (j < 4) begin
        a = qa[j+1]; b = qb[j+1]; cin = qc[j+1]; sub = qs[j+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end", 32'(busy), 32'd0);

    // Asynchronous reset during step 2
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_rst");
    run_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
